mesh_egress_port: RTL



---
 rtl/mesh_egress_port_pkg.sv | 31 +++
 rtl/mesh_egress_port_fifo.sv | 51 +++++
 rtl/mesh_egress_port.sv | 91 +++++++++
 3 files changed

// File: rtl/mesh_egress_port_pkg.sv
// mesh_egress_port_pkg: shared mesh router types, direction indices and helpers
package Mesh;

  localparam int NUM_DIRS = 5;
  localparam int DIR_S    = 0;
  localparam int DIR_W    = 1;
  localparam int DIR_N    = 2;
  localparam int DIR_E    = 3;
  localparam int DIR_C    = 4;

  typedef struct packed {
    logic [3:0]  dst_x;
    logic [3:0]  dst_y;
    logic [31:0] payload;
  } Packet;

  typedef struct packed {
    logic  valid;
    Packet pkt;
  } RouterIn;

  typedef struct packed {
    logic ready;
  } RouterOut;

  // Next round-robin index after a grant to idx, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mesh_egress_port_fifo.sv
// egress_fifo: packet buffer with wrapping pointers and occupancy count
module egress_fifo
  import Mesh::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  Packet din,
  input  logic  pop,
  output Packet dout,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  Packet          r_mem [DEPTH];
  logic [AW-1:0]  r_rd;
  logic [AW-1:0]  r_wr;
  logic [CW-1:0]  r_count;
  logic           w_push;
  logic           w_pop;

  assign full   = r_count == CW'(DEPTH);
  assign empty  = r_count == '0;
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rd];

  // Storage is not reset: contents are only observable while count != 0.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/mesh_egress_port.sv
// mesh_egress_port: round-robin arbiter + FIFO output stage; MESH_EGRESS_STATS_EN adds sent/stall counters
module mesh_egress_port
  import Mesh::*;
#(
  parameter int NUM_IN = 5,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IN-1:0]   request,
  input  Packet [NUM_IN-1:0]  packet_in,
  output logic [NUM_IN-1:0]   grant,
  output Packet               packet_out,
  output logic                valid,
  input  logic                ready
`ifdef MESH_EGRESS_STATS_EN
  ,
  output logic [31:0]         sent_count,
  output logic [31:0]         stall_count
`endif
);

  localparam int IW = $clog2(NUM_IN);

  logic [IW-1:0] r_rr;
  logic [IW-1:0] w_gidx;
  logic [IW-1:0] w_idx;
  logic          w_hit;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_xfer;

  assign valid  = !w_empty;
  assign w_xfer = valid && ready;
  assign w_push = |grant;

  // First requester at or above the RR pointer; suppressed when full or in reset.
  always_comb begin
    grant  = '0;
    w_gidx = '0;
    w_idx  = '0;
    w_hit  = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_idx = IW'((int'(r_rr) + k) % NUM_IN);
      if (!w_hit && request[w_idx]) begin
        w_hit         = 1'b1;
        w_gidx        = w_idx;
        grant[w_idx]  = 1'b1;
      end
    end
    if (!rst_n || w_full) grant = '0;
  end

  // Winner moves to lowest priority; pointer holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (!rst_n) r_rr <= '0;
    else if (w_push) r_rr <= IW'(rr_next(int'(w_gidx), NUM_IN));
  end

  egress_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (packet_in[w_gidx]),
    .pop   (w_xfer),
    .dout  (packet_out),
    .full  (w_full),
    .empty (w_empty)
  );

`ifdef MESH_EGRESS_STATS_EN
  logic [31:0] r_sent;
  logic [31:0] r_stall;

  assign sent_count  = r_sent;
  assign stall_count = r_stall;

  // Saturating transfer and backpressure counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sent  <= '0;
      r_stall <= '0;
    end else begin
      if (w_xfer && r_sent != '1) r_sent <= r_sent + 1'b1;
      if (valid && !ready && r_stall != '1) r_stall <= r_stall + 1'b1;
    end
  end
`endif

endmodule
